// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat bundle between two pipeline stages: payload plus control field.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready stalls, optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int                DATA_W   = 128,
  parameter int                CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter int                SKID     = 1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  pipe_stage_reg_if.slave   up_if,
  pipe_stage_reg_if.master  dn_if,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic out_valid;
  logic in_ready;
  logic accept;
  logic emit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign out_valid = (state_q != ST_EMPTY);
  // Without the skid entry, ready must look through to the downstream stall.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || dn_if.ready);
  assign accept    = up_if.valid && in_ready;
  assign emit      = out_valid && dn_if.ready;

  assign up_if.ready = in_ready;
  assign dn_if.valid = out_valid;
  assign dn_if.data  = out_data_q;
  assign dn_if.ctrl  = out_ctrl_q;
  assign stall_cnt_o = cnt_q;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d    = ST_FULL;
          out_data_d = up_if.data;
          out_ctrl_d = up_if.ctrl;
        end
      end
      ST_FULL: begin
        if (accept && emit) begin
          out_data_d = up_if.data;
          out_ctrl_d = up_if.ctrl;
        end else if (accept) begin
          state_d     = ST_SKID;
          skid_data_d = up_if.data;
          skid_ctrl_d = up_if.ctrl;
        end else if (emit) begin
          state_d    = ST_EMPTY;
          out_ctrl_d = CTRL_RST;
        end
      end
      ST_SKID: begin
        if (emit) begin
          state_d    = ST_FULL;
          out_data_d = skid_data_q;
          out_ctrl_d = skid_ctrl_q;
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        out_ctrl_d = CTRL_RST;
      end
    endcase

    // Flush drops everything held and the incoming beat; payload is left stale.
    if (flush_i) begin
      state_d    = ST_EMPTY;
      out_data_d = out_data_q;
      out_ctrl_d = CTRL_RST;
    end

    in_ready_d = (state_d != ST_SKID);
    cnt_d      = (out_valid && !dn_if.ready) ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_ctrl_q <= CTRL_RST;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Skid entry is only meaningful in ST_SKID, so it needs no reset.
  always_ff @(posedge clk_i) begin
    skid_data_q <= skid_data_d;
    skid_ctrl_q <= skid_ctrl_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-entry instance side by side,
// each with a queue scoreboard filled on accept and drained on emit.
module tb_pipe_stage_reg;
  localparam int              DW   = 32;
  localparam int              CW   = 12;
  localparam logic [CW-1:0]   CRST = 12'hA5C;

  logic clk;
  logic rst;
  logic flush;
  logic [3:0]  a_cnt;
  logic [15:0] b_cnt;

  int checks;
  int errors;

  logic [CW+DW-1:0] q_a[$];
  logic [CW+DW-1:0] q_b[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_up ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_dn ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_up ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_dn ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(1), .CNT_W(4)) u_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .up_if(a_up), .dn_if(a_dn), .stall_cnt_o(a_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST), .SKID(0), .CNT_W(16)) u_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .up_if(b_up), .dn_if(b_dn), .stall_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  // Scoreboards: an emit at the coming edge pops first, then flush/reset clear, then accept pushes.
  always @(negedge clk) begin
    logic [CW+DW-1:0] exp;
    if (rst) begin
      q_a.delete();
    end else begin
      if (a_dn.valid === 1'b1 && a_dn.ready === 1'b1) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL a_emit_unexpected got=%h expected=none", {a_dn.ctrl, a_dn.data});
        end else begin
          exp = q_a.pop_front();
          if ({a_dn.ctrl, a_dn.data} !== exp) begin
            errors++;
            $display("FAIL a_emit got=%h expected=%h", {a_dn.ctrl, a_dn.data}, exp);
          end
        end
      end
      if (a_dn.valid === 1'b0) begin
        checks++;
        if (a_dn.ctrl !== CRST) begin
          errors++;
          $display("FAIL a_idle_ctrl got=%h expected=%h", a_dn.ctrl, CRST);
        end
      end
      if (flush) q_a.delete();
      else if (a_up.valid === 1'b1 && a_up.ready === 1'b1) q_a.push_back({a_up.ctrl, a_up.data});
    end
  end

  always @(negedge clk) begin
    logic [CW+DW-1:0] exp;
    if (rst) begin
      q_b.delete();
    end else begin
      if (b_dn.valid === 1'b1 && b_dn.ready === 1'b1) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_emit_unexpected got=%h expected=none", {b_dn.ctrl, b_dn.data});
        end else begin
          exp = q_b.pop_front();
          if ({b_dn.ctrl, b_dn.data} !== exp) begin
            errors++;
            $display("FAIL b_emit got=%h expected=%h", {b_dn.ctrl, b_dn.data}, exp);
          end
        end
      end
      if (b_dn.valid === 1'b0) begin
        checks++;
        if (b_dn.ctrl !== CRST) begin
          errors++;
          $display("FAIL b_idle_ctrl got=%h expected=%h", b_dn.ctrl, CRST);
        end
      end
      if (flush) q_b.delete();
      else if (b_up.valid === 1'b1 && b_up.ready === 1'b1) q_b.push_back({b_up.ctrl, b_up.data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_up.valid = 1'b0; a_up.data = '0; a_up.ctrl = '0; a_dn.ready = 1'b1;
    b_up.valid = 1'b0; b_up.data = '0; b_up.ctrl = '0; b_dn.ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_up.valid = 1'b1; a_up.data = 32'hDEAD_BEEF; a_up.ctrl = 12'h123;
    b_up.valid = 1'b1; b_up.data = 32'hCAFE_F00D; b_up.ctrl = 12'h321;
    step();
    step();
    checks++;
    if ({a_dn.valid, a_dn.ctrl, a_up.ready, a_cnt, a_dn.data} !== {1'b0, CRST, 1'b1, 4'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_a got v=%b c=%h r=%b n=%0d d=%h expected v=0 c=%h r=1 n=0 d=0",
               a_dn.valid, a_dn.ctrl, a_up.ready, a_cnt, a_dn.data, CRST);
    end
    checks++;
    if ({b_dn.valid, b_dn.ctrl, b_up.ready, b_cnt, b_dn.data} !== {1'b0, CRST, 1'b1, 16'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_b got v=%b c=%h r=%b n=%0d d=%h expected v=0 c=%h r=1 n=0 d=0",
               b_dn.valid, b_dn.ctrl, b_up.ready, b_cnt, b_dn.data, CRST);
    end
    rst = 1'b0;
    idle_inputs();
    step();
    checks++;
    if (a_dn.valid !== 1'b0 || b_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_nothing_accepted got a=%b b=%b expected 0 0", a_dn.valid, b_dn.valid);
    end
  endtask

  task automatic test_stream();
    idle_inputs();
    for (int i = 1; i <= 8; i++) begin
      a_up.valid = 1'b1; a_up.data = i; a_up.ctrl = CW'(12'h100 + i);
      b_up.valid = 1'b1; b_up.data = i; b_up.ctrl = CW'(12'h100 + i);
      step();
      checks++;
      if (a_dn.valid !== 1'b1 || a_dn.data !== DW'(i) || b_dn.valid !== 1'b1 || b_dn.data !== DW'(i)) begin
        errors++;
        $display("FAIL stream_beat%0d got a=%b/%0d b=%b/%0d expected 1/%0d", i,
                 a_dn.valid, a_dn.data, b_dn.valid, b_dn.data, i);
      end
    end
    idle_inputs();
    step();
    step();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0 || a_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got qa=%0d qb=%0d v=%b expected 0 0 0", q_a.size(), q_b.size(), a_dn.valid);
    end
  endtask

  task automatic test_skid();
    idle_inputs();
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'hAAAA_0001; a_up.ctrl = 12'h00A;
    step();
    a_up.data = 32'hBBBB_0002; a_up.ctrl = 12'h00B;
    checks++;
    if (a_up.ready !== 1'b1 || a_dn.data !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL skid_full got r=%b d=%h expected 1 aaaa0001", a_up.ready, a_dn.data);
    end
    step();
    a_up.valid = 1'b0;
    checks++;
    if (a_up.ready !== 1'b0 || a_dn.valid !== 1'b1 || a_dn.data !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL skid_enter got r=%b v=%b d=%h expected 0 1 aaaa0001", a_up.ready, a_dn.valid, a_dn.data);
    end
    step();
    checks++;
    if (a_up.ready !== 1'b0 || a_dn.data !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL skid_hold got r=%b d=%h expected 0 aaaa0001", a_up.ready, a_dn.data);
    end
    a_dn.ready = 1'b1;
    step();
    checks++;
    if (a_up.ready !== 1'b1 || a_dn.valid !== 1'b1 || a_dn.data !== 32'hBBBB_0002) begin
      errors++;
      $display("FAIL skid_release got r=%b v=%b d=%h expected 1 1 bbbb0002", a_up.ready, a_dn.valid, a_dn.data);
    end
    step();
    checks++;
    if (a_dn.valid !== 1'b0 || q_a.size() != 0) begin
      errors++;
      $display("FAIL skid_drain got v=%b q=%0d expected 0 0", a_dn.valid, q_a.size());
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'h0000_00A1; a_up.ctrl = 12'h0A1;
    step();
    a_up.data = 32'h0000_00B2; a_up.ctrl = 12'h0B2;
    step();
    a_up.data = 32'h0000_00C3; a_up.ctrl = 12'h0C3;
    flush = 1'b1;
    step();
    flush = 1'b0;
    a_up.valid = 1'b0;
    checks++;
    if ({a_dn.valid, a_dn.ctrl, a_up.ready, a_dn.data} !== {1'b0, CRST, 1'b1, 32'h0000_00A1}) begin
      errors++;
      $display("FAIL flush_skid got v=%b c=%h r=%b d=%h expected 0 %h 1 000000a1",
               a_dn.valid, a_dn.ctrl, a_up.ready, a_dn.data, CRST);
    end
    a_dn.ready = 1'b1;
    step(); step(); step();
    checks++;
    if (a_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_emit got v=%b expected 0", a_dn.valid);
    end
    // Flush with a ready input and a same-cycle emit on both instances.
    a_up.valid = 1'b1; a_up.data = 32'h0000_00D4; a_up.ctrl = 12'h0D4;
    b_up.valid = 1'b1; b_up.data = 32'h0000_00D4; b_up.ctrl = 12'h0D4;
    step();
    a_up.data = 32'h0000_00E5; b_up.data = 32'h0000_00E5;
    flush = 1'b1;
    step();
    flush = 1'b0;
    a_up.valid = 1'b0; b_up.valid = 1'b0;
    checks++;
    if (a_dn.valid !== 1'b0 || b_dn.valid !== 1'b0 || a_up.ready !== 1'b1 || b_dn.data !== 32'h0000_00D4) begin
      errors++;
      $display("FAIL flush_full got av=%b bv=%b ar=%b bd=%h expected 0 0 1 000000d4",
               a_dn.valid, b_dn.valid, a_up.ready, b_dn.data);
    end
    step(); step();
    checks++;
    if (a_dn.valid !== 1'b0 || b_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard got av=%b bv=%b expected 0 0", a_dn.valid, b_dn.valid);
    end
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_dn.ready = 1'b0;
    a_up.valid = 1'b1; a_up.data = 32'h5555_0000; a_up.ctrl = 12'h055;
    step();
    a_up.valid = 1'b0;
    repeat (5) step();
    checks++;
    if (a_cnt !== 4'd5) begin
      errors++;
      $display("FAIL stall_count got=%0d expected=5", a_cnt);
    end
    repeat (15) step();
    checks++;
    if (a_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_saturate got=%0d expected=15", a_cnt);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    checks++;
    if (a_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_flush got=%0d expected=15", a_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if (a_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stall_reset_idle got=%0d expected=0", a_cnt);
    end
    a_dn.ready = 1'b1;
  endtask

  task automatic test_noskid();
    idle_inputs();
    b_up.valid = 1'b1; b_up.data = 32'h0000_0033; b_up.ctrl = 12'h033;
    step();
    b_up.valid = 1'b0;
    b_dn.ready = 1'b0;
    #1;
    checks++;
    if (b_up.ready !== 1'b0) begin
      errors++;
      $display("FAIL noskid_ready_low got=%b expected=0", b_up.ready);
    end
    b_up.valid = 1'b1; b_up.data = 32'h0000_0077; b_up.ctrl = 12'h077;
    step();
    checks++;
    if (b_dn.data !== 32'h0000_0033 || b_cnt !== 16'd1) begin
      errors++;
      $display("FAIL noskid_hold got d=%h n=%0d expected 00000033 1", b_dn.data, b_cnt);
    end
    b_dn.ready = 1'b1;
    b_up.data = 32'h0000_005A; b_up.ctrl = 12'h05A;
    #1;
    checks++;
    if (b_up.ready !== 1'b1) begin
      errors++;
      $display("FAIL noskid_ready_high got=%b expected=1", b_up.ready);
    end
    step();
    b_up.valid = 1'b0;
    checks++;
    if (b_dn.valid !== 1'b1 || b_dn.data !== 32'h0000_005A) begin
      errors++;
      $display("FAIL noskid_pass got v=%b d=%h expected 1 0000005a", b_dn.valid, b_dn.data);
    end
    step();
    checks++;
    if (b_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL noskid_drain got v=%b expected 0", b_dn.valid);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 300; i++) begin
      a_up.valid = ($urandom_range(3) != 0); a_up.data = $urandom; a_up.ctrl = CW'($urandom);
      b_up.valid = ($urandom_range(3) != 0); b_up.data = $urandom; b_up.ctrl = CW'($urandom);
      a_dn.ready = ($urandom_range(2) != 0);
      b_dn.ready = ($urandom_range(2) != 0);
      step();
    end
    idle_inputs();
    repeat (4) step();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0 || a_dn.valid !== 1'b0 || b_dn.valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain got qa=%0d qb=%0d av=%b bv=%b expected 0 0 0 0",
               q_a.size(), q_b.size(), a_dn.valid, b_dn.valid);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturation();
    test_noskid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
